// File: rtl/lm_log_arbiter.sv
// lm_log_arbiter: logging-module core. Captures UART errors, CM errors,
// configuration changes and UART data bytes into one-deep pending slots,
// picks one by fixed priority and emits it as a 2-byte record
// (header, payload) on a valid/ready byte stream.
module lm_log_arbiter #(
    parameter int WIDTH_UART_DATA     = 8,
    parameter int WIDTH_VGA_ERROR     = 4,
    parameter int WIDTH_UART_ERROR    = 3,
    parameter int WIDTH_CONFIGURATION = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           UART_data_debug_switch,
    input  logic [WIDTH_UART_DATA-1:0]     UART_data,
    input  logic                           UART_data_valid,
    input  logic [WIDTH_VGA_ERROR-1:0]     CM_errors,
    input  logic                           CM_errors_valid,
    input  logic [WIDTH_UART_ERROR-1:0]    UART_errors,
    input  logic                           UART_errors_valid,
    input  logic [WIDTH_CONFIGURATION-1:0] config_notification,
    output logic [7:0]                     out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     drop_count,
    output logic                           busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;

    logic [1:0] st_q, st_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] pay_q, pay_d;

    logic                          ue_pend_q, ue_pend_d;
    logic                          ue_ovf_q, ue_ovf_d;
    logic [WIDTH_UART_ERROR-1:0]   ue_val_q, ue_val_d;

    logic                          cm_pend_q, cm_pend_d;
    logic                          cm_ovf_q, cm_ovf_d;
    logic [WIDTH_VGA_ERROR-1:0]    cm_val_q, cm_val_d;

    logic                           cf_pend_q, cf_pend_d;
    logic                           cf_ovf_q, cf_ovf_d;
    logic [WIDTH_CONFIGURATION-1:0] cf_val_q, cf_val_d;
    logic [WIDTH_CONFIGURATION-1:0] cfg_prev_q, cfg_prev_d;

    logic                       dt_pend_q, dt_pend_d;
    logic [WIDTH_UART_DATA-1:0] dt_val_q, dt_val_d;

    logic [7:0] drop_q, drop_d;

    logic g_ue, g_cm, g_cf, g_dt;

    // Arbitration, record FSM and slot capture (capture sees the winner's slot as already freed)
    always_comb begin
        st_d       = st_q;
        hdr_d      = hdr_q;
        pay_d      = pay_q;
        ue_pend_d  = ue_pend_q;
        ue_ovf_d   = ue_ovf_q;
        ue_val_d   = ue_val_q;
        cm_pend_d  = cm_pend_q;
        cm_ovf_d   = cm_ovf_q;
        cm_val_d   = cm_val_q;
        cf_pend_d  = cf_pend_q;
        cf_ovf_d   = cf_ovf_q;
        cf_val_d   = cf_val_q;
        cfg_prev_d = config_notification;
        dt_pend_d  = dt_pend_q;
        dt_val_d   = dt_val_q;
        drop_d     = drop_q;
        g_ue       = 1'b0;
        g_cm       = 1'b0;
        g_cf       = 1'b0;
        g_dt       = 1'b0;

        case (st_q)
            ST_IDLE: begin
                if (ue_pend_q) begin
                    g_ue  = 1'b1;
                    hdr_d = {3'b001, ue_ovf_q, 4'b0000};
                    pay_d = 8'(ue_val_q);
                end else if (cm_pend_q) begin
                    g_cm  = 1'b1;
                    hdr_d = {3'b010, cm_ovf_q, 4'b0000};
                    pay_d = 8'(cm_val_q);
                end else if (cf_pend_q) begin
                    g_cf  = 1'b1;
                    hdr_d = {3'b011, cf_ovf_q, 4'b0000};
                    pay_d = 8'(cf_val_q);
                end else if (dt_pend_q) begin
                    g_dt  = 1'b1;
                    hdr_d = {3'b100, 1'b0, 4'b0000};
                    pay_d = 8'(dt_val_q);
                end
                if (ue_pend_q || cm_pend_q || cf_pend_q || dt_pend_q) begin
                    st_d = ST_HDR;
                end
            end
            ST_HDR:  if (out_ready) st_d = ST_PAY;
            ST_PAY:  if (out_ready) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase

        if (g_ue) begin ue_pend_d = 1'b0; ue_ovf_d = 1'b0; end
        if (g_cm) begin cm_pend_d = 1'b0; cm_ovf_d = 1'b0; end
        if (g_cf) begin cf_pend_d = 1'b0; cf_ovf_d = 1'b0; end
        if (g_dt) dt_pend_d = 1'b0;

        if (UART_errors_valid) begin
            if (ue_pend_q && !g_ue) begin
                ue_val_d = ue_val_q | UART_errors;
                ue_ovf_d = 1'b1;
            end else begin
                ue_val_d = UART_errors;
                ue_ovf_d = 1'b0;
            end
            ue_pend_d = 1'b1;
        end

        if (CM_errors_valid) begin
            if (cm_pend_q && !g_cm) begin
                cm_val_d = cm_val_q | CM_errors;
                cm_ovf_d = 1'b1;
            end else begin
                cm_val_d = CM_errors;
                cm_ovf_d = 1'b0;
            end
            cm_pend_d = 1'b1;
        end

        if (config_notification != cfg_prev_q) begin
            cf_ovf_d  = cf_pend_q && !g_cf;
            cf_val_d  = config_notification;
            cf_pend_d = 1'b1;
        end

        if (!UART_data_debug_switch) begin
            dt_pend_d = 1'b0;
        end else if (UART_data_valid) begin
            if (dt_pend_q && !g_dt) begin
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else begin
                dt_val_d  = UART_data;
                dt_pend_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            hdr_q      <= '0;
            pay_q      <= '0;
            ue_pend_q  <= 1'b0;
            ue_ovf_q   <= 1'b0;
            ue_val_q   <= '0;
            cm_pend_q  <= 1'b0;
            cm_ovf_q   <= 1'b0;
            cm_val_q   <= '0;
            cf_pend_q  <= 1'b0;
            cf_ovf_q   <= 1'b0;
            cf_val_q   <= '0;
            cfg_prev_q <= '0;
            dt_pend_q  <= 1'b0;
            dt_val_q   <= '0;
            drop_q     <= '0;
        end else begin
            st_q       <= st_d;
            hdr_q      <= hdr_d;
            pay_q      <= pay_d;
            ue_pend_q  <= ue_pend_d;
            ue_ovf_q   <= ue_ovf_d;
            ue_val_q   <= ue_val_d;
            cm_pend_q  <= cm_pend_d;
            cm_ovf_q   <= cm_ovf_d;
            cm_val_q   <= cm_val_d;
            cf_pend_q  <= cf_pend_d;
            cf_ovf_q   <= cf_ovf_d;
            cf_val_q   <= cf_val_d;
            cfg_prev_q <= cfg_prev_d;
            dt_pend_q  <= dt_pend_d;
            dt_val_q   <= dt_val_d;
            drop_q     <= drop_d;
        end
    end

    // Output byte selection from the latched record
    always_comb begin
        out_data = 8'h00;
        if (st_q == ST_HDR) out_data = hdr_q;
        else if (st_q == ST_PAY) out_data = pay_q;
    end

    assign out_valid  = (st_q == ST_HDR) || (st_q == ST_PAY);
    assign busy       = out_valid || ue_pend_q || cm_pend_q || cf_pend_q || dt_pend_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_lm_log_arbiter.sv
// tb_lm_log_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model of the logger.
module tb_lm_log_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       UART_data_debug_switch = 1'b0;
    logic [7:0] UART_data = '0;
    logic       UART_data_valid = 1'b0;
    logic [3:0] CM_errors = '0;
    logic       CM_errors_valid = 1'b0;
    logic [2:0] UART_errors = '0;
    logic       UART_errors_valid = 1'b0;
    logic [3:0] config_notification = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] drop_count;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: index 0 UART_ERR, 1 CM_ERR, 2 CFG, 3 DATA (priority order)
    bit         m_pend[4];
    bit         m_ovf[4];
    logic [7:0] m_val[4];
    logic [3:0] m_prev;
    int         m_drop;
    logic [7:0] m_rec[$];
    logic [7:0] acc[$];

    lm_log_arbiter #(
        .WIDTH_UART_DATA(8),
        .WIDTH_VGA_ERROR(4),
        .WIDTH_UART_ERROR(3),
        .WIDTH_CONFIGURATION(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .UART_data_debug_switch(UART_data_debug_switch),
        .UART_data(UART_data),
        .UART_data_valid(UART_data_valid),
        .CM_errors(CM_errors),
        .CM_errors_valid(CM_errors_valid),
        .UART_errors(UART_errors),
        .UART_errors_valid(UART_errors_valid),
        .config_notification(config_notification),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .drop_count(drop_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        bit found;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0; m_ovf[i] = 0; m_val[i] = '0;
            end
            m_prev = '0;
            m_drop = 0;
            m_rec.delete();
            return;
        end
        if (m_rec.size() == 0) begin
            found = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && m_pend[i]) begin
                    logic [2:0] tag;
                    tag = 3'(i + 1);
                    m_rec.push_back({tag, m_ovf[i], 4'b0000});
                    m_rec.push_back(m_val[i]);
                    m_pend[i] = 0;
                    m_ovf[i]  = 0;
                    found     = 1;
                end
            end
        end else if (out_ready) begin
            void'(m_rec.pop_front());
        end
        if (UART_errors_valid) begin
            m_ovf[0] = m_pend[0];
            m_val[0] = m_pend[0] ? (m_val[0] | {5'b0, UART_errors}) : {5'b0, UART_errors};
            m_pend[0] = 1;
        end
        if (CM_errors_valid) begin
            m_ovf[1] = m_pend[1];
            m_val[1] = m_pend[1] ? (m_val[1] | {4'b0, CM_errors}) : {4'b0, CM_errors};
            m_pend[1] = 1;
        end
        if (config_notification != m_prev) begin
            m_ovf[2]  = m_pend[2];
            m_val[2]  = {4'b0, config_notification};
            m_pend[2] = 1;
        end
        m_prev = config_notification;
        if (!UART_data_debug_switch) begin
            m_pend[3] = 0;
        end else if (UART_data_valid) begin
            if (m_pend[3]) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_val[3]  = UART_data;
                m_pend[3] = 1;
            end
        end
    endtask

    // One clock: record handshakes, step the model, then compare away from the edge
    task automatic tick();
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy;
        if (!rst && out_valid === 1'b1 && out_ready) acc.push_back(out_data);
        model_step();
        @(posedge clk);
        @(negedge clk);
        e_valid = (m_rec.size() != 0);
        e_data  = e_valid ? m_rec[0] : 8'h00;
        e_busy  = e_valid || m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3];
        check("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        check("out_data", {24'b0, out_data}, {24'b0, e_data});
        check("busy", {31'b0, busy}, {31'b0, e_busy});
        check("drop_count", {24'b0, drop_count}, 32'(m_drop));
    endtask

    task automatic check_acc(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(acc.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < acc.size(); i++)
            check(tag, {24'b0, acc[i]}, {24'b0, exp[i]});
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", {24'b0, out_data}, 32'd0);
        check("rst_drop", {24'b0, drop_count}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);

        // Single UART error record and its latency
        acc.delete();
        out_ready = 1'b1;
        UART_errors = 3'b101; UART_errors_valid = 1'b1;
        tick();
        UART_errors_valid = 1'b0;
        check("t1_lat1", {31'b0, out_valid}, 32'd0);
        tick();
        check("t1_lat2", {31'b0, out_valid}, 32'd1);
        check("t1_hdr", {24'b0, out_data}, 32'h20);
        repeat (4) tick();
        check_acc("t1_rec", '{8'h20, 8'h05});

        // Three simultaneous sources, served in priority order
        acc.delete();
        CM_errors = 4'hA; CM_errors_valid = 1'b1;
        UART_errors = 3'b010; UART_errors_valid = 1'b1;
        config_notification = 4'h3;
        tick();
        CM_errors_valid = 1'b0; UART_errors_valid = 1'b0;
        repeat (12) tick();
        check_acc("t2_rec", '{8'h20, 8'h02, 8'h40, 8'h0A, 8'h60, 8'h03});

        // Held CM record: CM accumulation, data drops, saturation
        acc.delete();
        out_ready = 1'b0;
        CM_errors = 4'h8; CM_errors_valid = 1'b1;
        tick();
        CM_errors_valid = 1'b0;
        tick();
        check("t3_held_hdr", {24'b0, out_data}, 32'h40);
        CM_errors = 4'h1; CM_errors_valid = 1'b1; tick();
        CM_errors = 4'h4; tick();
        CM_errors_valid = 1'b0;
        UART_data_debug_switch = 1'b1; UART_data_valid = 1'b1;
        UART_data = 8'h11; tick();
        UART_data = 8'h22; tick();
        UART_data = 8'h33; tick();
        check("t3_drop2", {24'b0, drop_count}, 32'd2);
        check("t3_hold", {24'b0, out_data}, 32'h40);
        for (int i = 0; i < 300; i++) begin
            UART_data = 8'($urandom);
            tick();
        end
        check("t3_sat", {24'b0, drop_count}, 32'hFF);
        UART_data_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        check_acc("t3_rec", '{8'h40, 8'h08, 8'h50, 8'h05, 8'h80, 8'h11});
        UART_data_debug_switch = 1'b0; UART_data_valid = 1'b1;
        repeat (10) tick();
        UART_data_valid = 1'b0;
        check("t3_sw_off_len", 32'(acc.size()), 32'd6);
        check("t3_sw_off_drop", {24'b0, drop_count}, 32'hFF);

        // Reset during PAY, then a config record
        UART_errors = 3'b001; UART_errors_valid = 1'b1;
        tick();
        UART_errors_valid = 1'b0;
        tick(); tick();
        out_ready = 1'b0;
        tick();
        check("t6_pay", {24'b0, out_data}, 32'h01);
        rst = 1'b1; config_notification = 4'h9;
        tick();
        check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        check("t6_rst_drop", {24'b0, drop_count}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        acc.delete();
        repeat (6) tick();
        check_acc("t6_rec", '{8'h60, 8'h09});

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst                 = ($urandom_range(0, 299) == 0);
            UART_errors_valid   = ($urandom_range(0, 9) == 0);
            UART_errors         = 3'($urandom);
            CM_errors_valid     = ($urandom_range(0, 7) == 0);
            CM_errors           = 4'($urandom);
            if ($urandom_range(0, 14) == 0) config_notification = 4'($urandom);
            UART_data_valid     = ($urandom_range(0, 2) == 0);
            UART_data           = 8'($urandom);
            if ($urandom_range(0, 49) == 0) UART_data_debug_switch = ~UART_data_debug_switch;
            out_ready           = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
